// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation runs accept -> execute -> respond; only one is in flight at a time.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic            rsp0_valid,
    output logic            rsp1_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,

    output logic [3:0]      alu_ctl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              owner_q, owner_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              grant1;
    logic              handshake;
    logic              legalOp;

    // On a tie, the port that did not win last time gets the grant.
    assign grant1     = req1_valid && (!req0_valid || !lastGrant_q);
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant1;
    assign req1_ready = !rst && (state_q == IDLE) && grant1;
    assign handshake  = req0_ready || req1_ready;

    assign rsp0_valid = !rst && (state_q == RESP) && !owner_q;
    assign rsp1_valid = !rst && (state_q == RESP) && owner_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    assign alu_ctl    = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

    always_comb begin
        legalOp = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: legalOp = 1'b1;
            default:                   legalOp = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    owner_d     = grant1;
                    lastGrant_d = grant1;
                    op_d        = grant1 ? req1_op : req0_op;
                    a_d         = grant1 ? req1_a  : req0_a;
                    b_d         = grant1 ? req1_b  : req0_b;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                zero_d   = alu_zero;
                err_d    = !legalOp;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any in-flight op and biases the next tie towards port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters: port 0 (execute stage) and port 1 (address/auxiliary unit).
- Arbitrates round-robin and sequences one operation at a time: accept, drive the ALU, capture, respond.
- Drives the ALU control and operand inputs from registers, and registers the ALU result and zero flag.
- Sits between the requesters and the ALU in the datapath.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  4  port 0 ALU control code.
- req0_a  in  XLEN  port 0 operand A.
- req0_b  in  XLEN  port 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  as port 0, for port 1.
- rsp0_valid  out  1  result valid for port 0.
- rsp1_valid  out  1  result valid for port 1.
- rsp_ready  in  1  response consumed; applies to whichever rsp*_valid is high.
- rsp_result  out  XLEN  registered ALU result.
- rsp_zero  out  1  registered ALU zero flag.
- rsp_err  out  1  op was not a legal ALU code.
- alu_ctl  out  4  to ALU control input.
- alu_a  out  XLEN  to ALU operand A.
- alu_b  out  XLEN  to ALU operand B.
- alu_out  in  XLEN  from ALU result.
- alu_zero  in  1  from ALU zero flag.

Behaviour:
- States: IDLE, EXEC, RESP. Reset is synchronous, rst sampled high at a rising edge:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - op_q=0, a_q=0, b_q=0, result/zero/err regs=0, owner=0.
  - All ready/valid outputs are 0 during and after reset.
- alu_ctl/alu_a/alu_b are always driven from op_q/a_q/b_q.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, only for the granted port.
  - Grant when both ports are valid: the port other than last_grant.
  - Grant when one port is valid: that port.
  - On handshake (valid & ready): latch op/a/b into op_q/a_q/b_q, owner=granted port, last_grant=granted port, go to EXEC.
  - The non-granted port sees ready=0 and must hold its request stable.
- EXEC (exactly 1 cycle):
  - ALU sees the latched inputs.
  - At the edge: result_q=alu_out, zero_q=alu_zero, err_q=(op_q not in {0000,0001,0010,0110,0111,1100}). Go to RESP.
- RESP:
  - rsp{owner}_valid=1; the other rsp valid stays 0.
  - rsp_result/rsp_zero/rsp_err are held stable until rsp_ready=1 at an edge; then go to IDLE.
  - No new request is accepted in RESP, even with rsp_ready high.
- Latency: handshake at edge T, EXEC during cycle T+1, rsp_valid high from cycle T+2. Minimum request-to-request interval is 3 cycles.
- Illegal op: the ALU returns 0, so result=0, zero=1, err=1. Not fatal; the response completes normally.
- Width: no extension or truncation; XLEN passed through.
- SLT semantics come from the ALU (unsigned compare); the arbiter does not interpret results.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped, no response is issued, and the next grant goes to port 0.
- A request deasserted before its handshake is never issued.
- rsp_ready while no rsp valid is high is ignored.

Test Plan:
- Port 0 only, op=0010, a=5, b=7, rsp_ready=1 → req0_ready in cycle 0; rsp0_valid in cycle 2 with result=12, zero=0, err=0; rsp1_valid stays 0.
- Port 1 only, op=0110, a=3, b=3 → rsp1_valid with result=0, zero=1. Then op=0111, a=2, b=9 → result=1, zero=0.
- Both ports valid continuously, each op=0001 with distinct operands → grants alternate 0,1,0,1. Each response is tagged to the correct port. No port is granted twice in a row while the other waits.
- rsp_ready held 0 for 5 cycles after rsp0_valid → result, zero and err stay stable; both req*_ready stay 0. Raising rsp_ready gives IDLE next cycle, then a new grant.
- op=0011, a=0xFFFFFFFF, b=1 → result=0, zero=1, err=1; the next legal op 1100 with a=0, b=0 gives result=0xFFFFFFFF, err=0.
- rst pulsed during EXEC of a port 1 op → no rsp1_valid. Afterwards, with both ports requesting, port 0 is granted first.
